accelerator_interface_sequencer: RTL

- Upstream neighbour of the DNC memory accelerator.
- Accepts the controller's flattened interface vector as a serial word stream with a valid/ready handshake.
- Splits the stream into the memory's read-head and write-head fields (k_read, beta_read, f_read, pi_read, k_write, beta_write, e_write, v_write, ga, gw).
- Drives each field onto the memory's data inputs with the matching I/K enable strobes, then pulses READY when the whole vector has been delivered.

---
 rtl/accelerator_interface_sequencer_if.sv | 21 ++
 rtl/accelerator_interface_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_interface_sequencer_if.sv
// Word-stream handshake carrying the controller's flattened interface vector
// into the sequencer.
interface accelerator_interface_sequencer_if #(
    parameter int DATA_SIZE = 64
);
    logic [DATA_SIZE-1:0] DATA_IN;
    logic                 DATA_IN_VALID;
    logic                 DATA_IN_READY;

    modport master (
        output DATA_IN,
        output DATA_IN_VALID,
        input  DATA_IN_READY
    );

    modport slave (
        input  DATA_IN,
        input  DATA_IN_VALID,
        output DATA_IN_READY
    );
endinterface

// File: rtl/accelerator_interface_sequencer.sv
// Splits the DNC interface vector stream into memory read/write head fields.
// Optional sticky OVERRUN flag: ACCELERATOR_INTERFACE_SEQUENCER_OVERRUN_EN.
module accelerator_interface_sequencer #(
    parameter int DATA_SIZE = 64,
    parameter int W         = 64,
    parameter int R         = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0] SIZE_W_IN,
    accelerator_interface_sequencer_if.slave din,
    output logic [DATA_SIZE-1:0] K_READ_OUT,
    output logic [DATA_SIZE-1:0] BETA_READ_OUT,
    output logic [DATA_SIZE-1:0] F_READ_OUT,
    output logic [DATA_SIZE-1:0] PI_READ_OUT,
    output logic [DATA_SIZE-1:0] K_WRITE_OUT,
    output logic [DATA_SIZE-1:0] BETA_WRITE_OUT,
    output logic [DATA_SIZE-1:0] E_WRITE_OUT,
    output logic [DATA_SIZE-1:0] V_WRITE_OUT,
    output logic [DATA_SIZE-1:0] GA_WRITE_OUT,
    output logic [DATA_SIZE-1:0] GW_WRITE_OUT,
    output logic                 K_READ_I_ENABLE,
    output logic                 K_READ_K_ENABLE,
    output logic                 BETA_READ_ENABLE,
    output logic                 F_READ_ENABLE,
    output logic                 PI_READ_ENABLE,
    output logic                 K_WRITE_K_ENABLE,
    output logic                 E_WRITE_K_ENABLE,
    output logic                 V_WRITE_K_ENABLE,
    output logic                 BETA_WRITE_ENABLE,
    output logic                 GA_WRITE_ENABLE,
    output logic                 GW_WRITE_ENABLE
`ifdef ACCELERATOR_INTERFACE_SEQUENCER_OVERRUN_EN
    ,
    output logic                 OVERRUN
`endif
);

    typedef enum logic [3:0] {
        IDLE, K_READ, BETA_READ, F_READ, PI_READ, K_WRITE,
        BETA_WRITE, E_WRITE, V_WRITE, GA_WRITE, GW_WRITE, DONE
    } state_t;

    localparam logic [DATA_SIZE-1:0] R_MAX = DATA_SIZE'(R);
    localparam logic [DATA_SIZE-1:0] W_MAX = DATA_SIZE'(W);
    localparam logic [DATA_SIZE-1:0] PI_LAST = DATA_SIZE'(2);

    localparam int B_GW  = 0;
    localparam int B_GA  = 1;
    localparam int B_VW  = 2;
    localparam int B_EW  = 3;
    localparam int B_BW  = 4;
    localparam int B_KW  = 5;
    localparam int B_PI  = 6;
    localparam int B_FR  = 7;
    localparam int B_BR  = 8;
    localparam int B_KRK = 9;
    localparam int B_KRI = 10;

    state_t               state, state_n, nf;
    logic [DATA_SIZE-1:0] i_cnt, i_n, k_cnt, k_n;
    logic [DATA_SIZE-1:0] sr, sw, sr_in, sw_in;
    logic [10:0]          stb, stb_n;
    logic                 ready_n, in_ready, accept;
    logic                 i_last, k_last;

    function automatic state_t succ(state_t s);
        unique case (s)
            IDLE:       return K_READ;
            K_READ:     return BETA_READ;
            BETA_READ:  return F_READ;
            F_READ:     return PI_READ;
            PI_READ:    return K_WRITE;
            K_WRITE:    return BETA_WRITE;
            BETA_WRITE: return E_WRITE;
            E_WRITE:    return V_WRITE;
            V_WRITE:    return GA_WRITE;
            GA_WRITE:   return GW_WRITE;
            GW_WRITE:   return DONE;
            default:    return IDLE;
        endcase
    endfunction

    function automatic logic is_empty(state_t s, logic rz, logic wz);
        unique case (s)
            K_READ:                     return rz | wz;
            BETA_READ, F_READ, PI_READ: return rz;
            K_WRITE, E_WRITE, V_WRITE:  return wz;
            default:                    return 1'b0;
        endcase
    endfunction

    // At most five consecutive fields can be empty (all reads plus K_WRITE).
    function automatic state_t next_field(state_t s, logic rz, logic wz);
        state_t n;
        n = succ(s);
        for (int j = 0; j < 5; j++)
            if (is_empty(n, rz, wz)) n = succ(n);
        return n;
    endfunction

    assign sr_in    = (SIZE_R_IN > R_MAX) ? R_MAX : SIZE_R_IN;
    assign sw_in    = (SIZE_W_IN > W_MAX) ? W_MAX : SIZE_W_IN;
    assign in_ready = (state != IDLE) && (state != DONE);
    assign accept   = in_ready && din.DATA_IN_VALID;
    assign i_last   = (i_cnt == sr - 1'b1);
    assign k_last   = (k_cnt == sw - 1'b1);
    assign nf       = next_field(state, sr == '0, sw == '0);

    assign din.DATA_IN_READY = in_ready;

    always_comb begin
        state_n = state;
        i_n     = i_cnt;
        k_n     = k_cnt;
        stb_n   = '0;
        ready_n = 1'b0;
        if (state == IDLE) begin
            if (START) state_n = next_field(IDLE, sr_in == '0, sw_in == '0);
        end else if (state == DONE) begin
            state_n = IDLE;
        end else if (accept) begin
            unique case (state)
                K_READ: begin
                    stb_n[B_KRK] = 1'b1;
                    stb_n[B_KRI] = (k_cnt == '0);
                    if (k_last) begin
                        k_n = '0;
                        if (i_last) begin
                            i_n     = '0;
                            state_n = nf;
                        end else begin
                            i_n = i_cnt + 1'b1;
                        end
                    end else begin
                        k_n = k_cnt + 1'b1;
                    end
                end
                BETA_READ, F_READ: begin
                    stb_n[B_BR] = (state == BETA_READ);
                    stb_n[B_FR] = (state == F_READ);
                    if (i_last) begin
                        i_n     = '0;
                        state_n = nf;
                    end else begin
                        i_n = i_cnt + 1'b1;
                    end
                end
                PI_READ: begin
                    stb_n[B_PI] = 1'b1;
                    if (k_cnt == PI_LAST) begin
                        k_n = '0;
                        if (i_last) begin
                            i_n     = '0;
                            state_n = nf;
                        end else begin
                            i_n = i_cnt + 1'b1;
                        end
                    end else begin
                        k_n = k_cnt + 1'b1;
                    end
                end
                K_WRITE, E_WRITE, V_WRITE: begin
                    stb_n[B_KW] = (state == K_WRITE);
                    stb_n[B_EW] = (state == E_WRITE);
                    stb_n[B_VW] = (state == V_WRITE);
                    if (k_last) begin
                        k_n     = '0;
                        state_n = nf;
                    end else begin
                        k_n = k_cnt + 1'b1;
                    end
                end
                BETA_WRITE, GA_WRITE: begin
                    stb_n[B_BW] = (state == BETA_WRITE);
                    stb_n[B_GA] = (state == GA_WRITE);
                    state_n     = nf;
                end
                GW_WRITE: begin
                    stb_n[B_GW] = 1'b1;
                    ready_n     = 1'b1;
                    state_n     = nf;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            i_cnt <= '0;
            k_cnt <= '0;
            sr    <= '0;
            sw    <= '0;
            stb   <= '0;
            READY <= 1'b0;
        end else begin
            state <= state_n;
            i_cnt <= i_n;
            k_cnt <= k_n;
            stb   <= stb_n;
            READY <= ready_n;
            if (state == IDLE && START) begin
                sr <= sr_in;
                sw <= sw_in;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            K_READ_OUT     <= '0;
            BETA_READ_OUT  <= '0;
            F_READ_OUT     <= '0;
            PI_READ_OUT    <= '0;
            K_WRITE_OUT    <= '0;
            BETA_WRITE_OUT <= '0;
            E_WRITE_OUT    <= '0;
            V_WRITE_OUT    <= '0;
            GA_WRITE_OUT   <= '0;
            GW_WRITE_OUT   <= '0;
        end else begin
            if (stb_n[B_KRK]) K_READ_OUT     <= din.DATA_IN;
            if (stb_n[B_BR])  BETA_READ_OUT  <= din.DATA_IN;
            if (stb_n[B_FR])  F_READ_OUT     <= din.DATA_IN;
            if (stb_n[B_PI])  PI_READ_OUT    <= din.DATA_IN;
            if (stb_n[B_KW])  K_WRITE_OUT    <= din.DATA_IN;
            if (stb_n[B_BW])  BETA_WRITE_OUT <= din.DATA_IN;
            if (stb_n[B_EW])  E_WRITE_OUT    <= din.DATA_IN;
            if (stb_n[B_VW])  V_WRITE_OUT    <= din.DATA_IN;
            if (stb_n[B_GA])  GA_WRITE_OUT   <= din.DATA_IN;
            if (stb_n[B_GW])  GW_WRITE_OUT   <= din.DATA_IN;
        end
    end

    assign K_READ_I_ENABLE   = stb[B_KRI];
    assign K_READ_K_ENABLE   = stb[B_KRK];
    assign BETA_READ_ENABLE  = stb[B_BR];
    assign F_READ_ENABLE     = stb[B_FR];
    assign PI_READ_ENABLE    = stb[B_PI];
    assign K_WRITE_K_ENABLE  = stb[B_KW];
    assign BETA_WRITE_ENABLE = stb[B_BW];
    assign E_WRITE_K_ENABLE  = stb[B_EW];
    assign V_WRITE_K_ENABLE  = stb[B_VW];
    assign GA_WRITE_ENABLE   = stb[B_GA];
    assign GW_WRITE_ENABLE   = stb[B_GW];

`ifdef ACCELERATOR_INTERFACE_SEQUENCER_OVERRUN_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            OVERRUN <= 1'b0;
        else if (state == IDLE && START)
            OVERRUN <= 1'b0;
        else if (din.DATA_IN_VALID && !in_ready)
            OVERRUN <= 1'b1;
    end
`endif

endmodule
